spi_master: RTL
===============

// Module: spi_master
// PURPOSE
// - SPI mode-0 master (CPOL=0, CPHA=0), MSB first, 8-bit words, SSEL active low.
// - Drives SCK/MOSI/SSEL to, and samples MISO from, our SPI slave, which syncs SCK/SSEL through 3 FFs.
// - Host side: valid/ready byte stream in, rx byte pulse out; tx_last closes the frame.
// PARAMETERS
// - CLK_DIV  4  clk cycles per SCK half-period; legal range >= 4, because the slave needs >= 3 clk per level.
// - CS_GAP   2  half-periods SSEL is held high between frames; legal range >= 1.
// PORTS
// - clk       in   1  system clock, all logic on posedge
// - rst_n     in   1  reset; asynchronous, active-low
// - tx_data   in   8  byte to transmit
// - tx_valid  in   1  tx_data/tx_last valid
// - tx_last   in   1  this byte ends the frame; SSEL deasserts after it
// - tx_ready  out  1  byte accepted when tx_valid && tx_ready
// - rx_data   out  8  byte shifted in from MISO; valid while rx_valid=1
// - rx_valid  out  1  one-clk pulse per completed byte
// - busy      out  1  1 in any state except IDLE
// - SCK       out  1  SPI clock, idle low
// - MOSI      out  1  serial data out
// - MISO      in   1  serial data in (async)
// - SSEL      out  1  slave select, active low
// BEHAVIOUR
// - Reset values (async, held while rst_n=0): state=IDLE, SSEL=1, SCK=0, MOSI=0, rx_valid=0, rx_data=0, busy=0.
// - tx_ready: combinational, 1 only in IDLE or WAIT; it is therefore 1 during reset.
// - States: IDLE -> LOW <-> HIGH -> (WAIT | HOLD) ; HOLD -> GAP -> IDLE ; WAIT -> LOW.
// - IDLE: accept in cycle t -> at t+1 SSEL=0, MOSI=tx_data[7], SCK=0; enter LOW.
//   - Latch tx_data into the shift reg and tx_last into last_q.
// - LOW: lasts CLK_DIV clk, then SCK=1 and enter HIGH.
// - HIGH: lasts CLK_DIV clk.
//   - In the last HIGH cycle, shift in the 2-FF-synced MISO; the sample point is the end of the high phase.
//   - Then SCK=0.
//   - If bits remain: MOSI = next bit on the same edge; enter LOW.
// - Byte end (8th HIGH phase ends): rx_valid=1 for exactly that 1 clk; rx_data holds until the next byte ends.
//   - SCK=0. Next state is HOLD if last_q=1, otherwise WAIT.
// - WAIT: SSEL stays 0, SCK 0, no time limit.
//   - Accept -> next cycle MOSI=bit7, enter LOW; this gives 1 extra clk of inter-byte gap.
// - HOLD: CLK_DIV clk with SCK=0, SSEL=0; then SSEL=1, enter GAP.
// - GAP: CS_GAP*CLK_DIV clk with SSEL=1, then IDLE. tx_ready=0 throughout.
// - Bit counter: 3 bits; wraps 7->0 at byte end; never exceeds 8 SCK rises per byte.
// - tx_valid while busy and not WAIT: ignored (not accepted); the host must hold it.
// - Reset mid-byte: immediate SSEL=1, SCK=0; no rx_valid; partial byte discarded.
// - MOSI is don't-care but held at its last value while SSEL=1. It never changes while SCK=1.
// STRUCTURE
// - Shared pkg spi_pkg: typedef enum {IDLE,LOW,HIGH,WAIT,HOLD,GAP} spi_mst_state_t; SPI_WORD_W=8.
// - Sub-module spi_sck_gen: half-period counter (CLK_DIV) emitting a 1-clk tick; cleared on state entry.
// - Top: FSM, tx/rx shift regs, bit counter, 2-FF MISO synchronizer.
// TESTING
// - Single byte 0xA5, tx_last=1, CLK_DIV=4:
//   - SSEL low for 8 SCK pulses; MOSI seq 1,0,1,0,0,1,0,1 on rises; each SCK high exactly 4 clk.
//   - Slave LED=1 after the frame.
// - Frame with the slave model: tx 0x3C then 0x00 (last) -> rx_valid twice: rx_data=0x00, then 0x3C.
//   - SSEL stays low across both bytes.
// - Back-to-back: tx_valid held high for 3 bytes -> exactly 1 clk WAIT between bytes; tx_ready pulses 3 times.
// - Stall in WAIT: host idle for 50 clk after byte 1 -> SSEL stays 0, SCK stays 0, no spurious rx_valid.
// - Gap: two 1-byte frames back-to-back -> SSEL high >= CS_GAP*CLK_DIV = 8 clk between frames.
// - Reset mid-byte: assert rst_n=0 after the 3rd SCK rise -> same-cycle SSEL=1, SCK=0.
//   - No rx_valid; next frame transfers correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI mode-0 master.
package spi_pkg;

   localparam int SPI_WORD_W    = 8;
   localparam int SPI_BIT_CNT_W = 3;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOW  = 3'd1,
      HIGH = 3'd2,
      WAIT = 3'd3,
      HOLD = 3'd4,
      GAP  = 3'd5
   } spi_mst_state_t;

   // The host may hand over a byte only between transfers.
   function automatic logic state_accepts(input spi_mst_state_t s);
      return (s == IDLE) || (s == WAIT);
   endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// Half-period timer: emits a one-clk tick on the last clk of every CLK_DIV-clk
// half-period; the count restarts whenever the FSM changes state.
module spi_sck_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int               CNT_W    = $clog2(CLK_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next half-period count.
   always_comb begin
      cnt_d = cnt_q;
      if (!en || clr) begin
         cnt_d = {CNT_W{1'b0}};
      end else if (cnt_q == CNT_LAST) begin
         cnt_d = {CNT_W{1'b0}};
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= {CNT_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = en && (cnt_q == CNT_LAST);

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master (CPOL=0, CPHA=0), MSB first, 8-bit words, active-low SSEL.
// Bytes arrive on a valid/ready stream; tx_last closes the frame.
module spi_master #(
   parameter int CLK_DIV = 4,
   parameter int CS_GAP  = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   input  logic       tx_last,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       busy,
   output logic       SCK,
   output logic       MOSI,
   input  logic       MISO,
   output logic       SSEL
);

   import spi_pkg::*;

   localparam int              GAP_W    = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

   spi_mst_state_t             state_q,    state_d;
   logic                       sck_q,      sck_d;
   logic                       mosi_q,     mosi_d;
   logic                       ssel_q,     ssel_d;
   logic                       rx_valid_q, rx_valid_d;
   logic [SPI_WORD_W-1:0]      rx_data_q,  rx_data_d;
   logic                       busy_q,     busy_d;
   logic [SPI_WORD_W-1:0]      tx_shift_q, tx_shift_d;
   logic [SPI_WORD_W-2:0]      rx_shift_q, rx_shift_d;
   logic [SPI_BIT_CNT_W-1:0]   bit_cnt_q,  bit_cnt_d;
   logic [GAP_W-1:0]           gap_cnt_q,  gap_cnt_d;
   logic                       last_q,     last_d;
   logic                       miso_s1_q,  miso_s2_q;

   logic gen_en_s;
   logic gen_clr_s;
   logic tick_s;

   assign gen_en_s  = (state_q == LOW) || (state_q == HIGH) ||
                      (state_q == HOLD) || (state_q == GAP);
   assign gen_clr_s = (state_d != state_q);

   spi_sck_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_sck_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (gen_en_s),
      .clr   (gen_clr_s),
      .tick  (tick_s)
   );

   // FSM next state, shift registers and next values of every registered output.
   always_comb begin
      state_d    = state_q;
      sck_d      = sck_q;
      mosi_d     = mosi_q;
      ssel_d     = ssel_q;
      rx_valid_d = 1'b0;
      rx_data_d  = rx_data_q;
      tx_shift_d = tx_shift_q;
      rx_shift_d = rx_shift_q;
      bit_cnt_d  = bit_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      last_d     = last_q;
      case (state_q)
         IDLE, WAIT: begin
            if (tx_valid) begin
               state_d    = LOW;
               ssel_d     = 1'b0;
               sck_d      = 1'b0;
               mosi_d     = tx_data[SPI_WORD_W-1];
               tx_shift_d = {tx_data[SPI_WORD_W-2:0], 1'b0};
               bit_cnt_d  = 3'd0;
               last_d     = tx_last;
            end else begin
               state_d = state_q;
            end
         end
         LOW: begin
            if (tick_s) begin
               state_d = HIGH;
               sck_d   = 1'b1;
            end else begin
               state_d = LOW;
            end
         end
         HIGH: begin
            if (tick_s) begin
               sck_d      = 1'b0;
               rx_shift_d = {rx_shift_q[SPI_WORD_W-3:0], miso_s2_q};
               bit_cnt_d  = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  rx_valid_d = 1'b1;
                  rx_data_d  = {rx_shift_q, miso_s2_q};
                  state_d    = last_q ? HOLD : WAIT;
               end else begin
                  // MOSI moves on the falling edge so it is stable through the next rise.
                  mosi_d     = tx_shift_q[SPI_WORD_W-1];
                  tx_shift_d = {tx_shift_q[SPI_WORD_W-2:0], 1'b0};
                  state_d    = LOW;
               end
            end else begin
               state_d = HIGH;
            end
         end
         HOLD: begin
            if (tick_s) begin
               ssel_d    = 1'b1;
               gap_cnt_d = {GAP_W{1'b0}};
               state_d   = GAP;
            end else begin
               state_d = HOLD;
            end
         end
         GAP: begin
            if (tick_s) begin
               if (gap_cnt_q == GAP_LAST) begin
                  state_d = IDLE;
               end else begin
                  gap_cnt_d = gap_cnt_q + GAP_W'(1);
               end
            end else begin
               state_d = GAP;
            end
         end
         default: begin
            state_d = IDLE;
            ssel_d  = 1'b1;
            sck_d   = 1'b0;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // State, datapath and output registers; MISO crosses in through two flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         sck_q      <= 1'b0;
         mosi_q     <= 1'b0;
         ssel_q     <= 1'b1;
         rx_valid_q <= 1'b0;
         rx_data_q  <= 8'h00;
         busy_q     <= 1'b0;
         tx_shift_q <= 8'h00;
         rx_shift_q <= 7'h00;
         bit_cnt_q  <= 3'd0;
         gap_cnt_q  <= {GAP_W{1'b0}};
         last_q     <= 1'b0;
         miso_s1_q  <= 1'b0;
         miso_s2_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         sck_q      <= sck_d;
         mosi_q     <= mosi_d;
         ssel_q     <= ssel_d;
         rx_valid_q <= rx_valid_d;
         rx_data_q  <= rx_data_d;
         busy_q     <= busy_d;
         tx_shift_q <= tx_shift_d;
         rx_shift_q <= rx_shift_d;
         bit_cnt_q  <= bit_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
         last_q     <= last_d;
         miso_s1_q  <= MISO;
         miso_s2_q  <= miso_s1_q;
      end
   end

   assign tx_ready = state_accepts(state_q);
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign busy     = busy_q;
   assign SCK      = sck_q;
   assign MOSI     = mosi_q;
   assign SSEL     = ssel_q;

endmodule
